uart_cmd_rx: RTL and testbench

- UART receiver at the platform end of the rider command link.
- Deserializes 8N1 frames sent by the remote/bench transmitter (the send_cmd / cmd_sent side) into the byte `cmd` with a `rdy` flag.
- Flags the two protocol commands, go (0x47 'G') and stop (0x53 'S'), with single-cycle strobes.
- Feeds the authorization/power-up logic downstream.

---
 rtl/uart_cmd_pkg.sv | 23 ++
 rtl/uart_cmd_rx_sync.sv | 33 +++
 rtl/uart_cmd_rx.sv | 182 ++++++++++++++++++
 tb/tb_uart_cmd_rx.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_pkg
// Purpose  : Shared types and constants for the rider command-link UART
//            receiver and its command tasks.
// Revision : 1.0 - initial release
// ============================================================================
package uart_cmd_pkg;

    // Receiver FSM: waiting for a start edge, or shifting in a frame
    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } rx_state_t;

    localparam logic [7:0] GO_CMD_DEF   = 8'h47;   // 'G'
    localparam logic [7:0] STOP_CMD_DEF = 8'h53;   // 'S'

    // start + 8 data + stop
    localparam int FRAME_BITS = 10;

endpackage : uart_cmd_pkg
`default_nettype wire

// File: rtl/uart_cmd_rx_sync.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_rx_sync
// Purpose  : Two-flop synchronizer for the asynchronous serial line. Both
//            flops preset high so the idle line level is seen while in reset
//            and no false start bit appears at reset release.
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_rx,
    output logic o_rx_sync
);

    logic meta_q;
    logic sync_q;

    // Double-register the raw line; preset to the idle (high) level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= i_rx;
            sync_q <= meta_q;
        end
    end

    assign o_rx_sync = sync_q;

endmodule : uart_cmd_rx_sync
`default_nettype wire

// File: rtl/uart_cmd_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_rx
// Purpose  : 8N1 UART receiver for the rider command link. Delivers each
//            received byte on cmd with a rdy level, and pulses cmd_go /
//            cmd_stop for one cycle when the byte is the go / stop command.
// Options  : UART_CMD_RX_FRAME_CHK_EN - when defined, a low stop bit drops
//            the frame and raises frm_err; otherwise the stop bit is ignored
//            and frm_err is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_rx
    import uart_cmd_pkg::*;
#(
    parameter int unsigned BAUD_CNT = 5208,          // clk cycles per bit, >= 8
    parameter logic [7:0]  GO_CMD   = GO_CMD_DEF,
    parameter logic [7:0]  STOP_CMD = STOP_CMD_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] cmd,
    output logic       rdy,
    output logic       cmd_go,
    output logic       cmd_stop,
    output logic       frm_err
);

    // The bit timer counts down to zero inclusive, so loads are one less
    // than the wanted interval: a bit then lasts exactly BAUD_CNT cycles.
    localparam int unsigned      CNT_W       = $clog2(BAUD_CNT);
    localparam logic [CNT_W-1:0] C_HALF_LOAD = CNT_W'(BAUD_CNT / 2 - 1);
    localparam logic [CNT_W-1:0] C_BIT_LOAD  = CNT_W'(BAUD_CNT - 1);
    localparam logic [3:0]       C_LAST_BIT  = 4'(FRAME_BITS - 1);

    rx_state_t               state_q, state_d;
    logic [CNT_W-1:0]        baud_cnt_q, baud_cnt_d;
    logic [3:0]              bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic [7:0]              cmd_q, cmd_d;
    logic                    rdy_q, rdy_d;
    logic                    cmd_go_q, cmd_go_d;
    logic                    cmd_stop_q, cmd_stop_d;
`ifdef UART_CMD_RX_FRAME_CHK_EN
    logic                    frm_err_q, frm_err_d;
`endif

    logic                    w_rx_sync;
    logic [FRAME_BITS-1:0]   w_shift_in;
    logic                    w_stop_ok;
    logic                    w_accept;
    logic                    w_unused;

    uart_cmd_rx_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_rx      (RX),
        .o_rx_sync (w_rx_sync)
    );

    // Next-state, bit timing, frame assembly and the rdy handshake
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        cmd_d      = cmd_q;
        rdy_d      = rdy_q;
        cmd_go_d   = 1'b0;
        cmd_stop_d = 1'b0;
        w_accept   = 1'b0;
        w_shift_in = {w_rx_sync, shift_q[FRAME_BITS-1:1]};
`ifdef UART_CMD_RX_FRAME_CHK_EN
        frm_err_d  = frm_err_q;
        w_stop_ok  = w_rx_sync;
`else
        w_stop_ok  = 1'b1;
`endif

        case (state_q)
            IDLE: begin
                if (!w_rx_sync) begin
                    // Start edge: first sample lands mid start bit
                    state_d    = RECV;
                    baud_cnt_d = C_HALF_LOAD;
                    bit_cnt_d  = 4'd0;
                    rdy_d      = 1'b0;
`ifdef UART_CMD_RX_FRAME_CHK_EN
                    frm_err_d  = 1'b0;
`endif
                end
            end
            RECV: begin
                if (baud_cnt_q == '0) begin
                    shift_d    = w_shift_in;
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                    baud_cnt_d = C_BIT_LOAD;
                    if ((bit_cnt_q == 4'd0) && w_rx_sync) begin
                        // Start bit gone by mid-bit: treat as a glitch
                        state_d = IDLE;
                    end else if (bit_cnt_q == C_LAST_BIT) begin
                        // Stop bit just sampled; frame is complete
                        state_d = IDLE;
                        if (w_stop_ok) begin
                            w_accept = 1'b1;
                        end else begin
`ifdef UART_CMD_RX_FRAME_CHK_EN
                            frm_err_d = 1'b1;
`endif
                        end
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (clr_rdy) begin
            rdy_d = 1'b0;
        end

        // A completing byte takes priority over a coincident clear
        if (w_accept) begin
            rdy_d      = 1'b1;
            cmd_d      = w_shift_in[8:1];
            cmd_go_d   = (w_shift_in[8:1] == GO_CMD);
            cmd_stop_d = (w_shift_in[8:1] == STOP_CMD);
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= 4'd0;
            shift_q    <= '0;
            cmd_q      <= 8'h00;
            rdy_q      <= 1'b0;
            cmd_go_q   <= 1'b0;
            cmd_stop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            cmd_q      <= cmd_d;
            rdy_q      <= rdy_d;
            cmd_go_q   <= cmd_go_d;
            cmd_stop_q <= cmd_stop_d;
        end
    end

`ifdef UART_CMD_RX_FRAME_CHK_EN
    // Framing-error flag, held until the next start edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_err_q <= 1'b0;
        end else begin
            frm_err_q <= frm_err_d;
        end
    end

    assign frm_err = frm_err_q;
`else
    assign frm_err = 1'b0;
`endif

    // The oldest bit is shifted out and never needed
    assign w_unused = shift_q[0];

    assign cmd      = cmd_q;
    assign rdy      = rdy_q;
    assign cmd_go   = cmd_go_q;
    assign cmd_stop = cmd_stop_q;

endmodule : uart_cmd_rx
`default_nettype wire

// File: tb/tb_uart_cmd_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cmd_rx
// Purpose  : Self-checking bench for uart_cmd_rx. Drives 8N1 frames at
//            16 clocks per bit and compares outputs with a byte-level model.
// Options  : UART_CMD_RX_FRAME_CHK_EN selects the framing-error expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_rx;
    import uart_cmd_pkg::*;

    localparam int B = 16;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       RX      = 1'b1;
    logic       clr_rdy = 1'b0;
    logic [7:0] cmd;
    logic       rdy;
    logic       cmd_go;
    logic       cmd_stop;
    logic       frm_err;

    int checks   = 0;
    int failures = 0;

    int cyc          = 0;
    int go_pulses    = 0;
    int stop_pulses  = 0;
    int rdy_rises    = 0;
    int frm_hi       = 0;
    int rdy_rise_cyc = 0;
    int start_cyc    = 0;
    logic rdy_prev   = 1'b0;

    logic [7:0] exp_cmd;
    logic [7:0] b;
    int g0, s0, r0, f0, gap, lat;

    uart_cmd_rx #(
        .BAUD_CNT (B),
        .GO_CMD   (GO_CMD_DEF),
        .STOP_CMD (STOP_CMD_DEF)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .RX       (RX),
        .clr_rdy  (clr_rdy),
        .cmd      (cmd),
        .rdy      (rdy),
        .cmd_go   (cmd_go),
        .cmd_stop (cmd_stop),
        .frm_err  (frm_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event counters observed away from the active edge
    always @(negedge clk) begin
        if (cmd_go)   go_pulses++;
        if (cmd_stop) stop_pulses++;
        if (frm_err)  frm_hi++;
        if (rdy && !rdy_prev) begin
            rdy_rises++;
            rdy_rise_cyc = cyc;
        end
        rdy_prev = rdy;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One 8N1 frame, LSB first; called and returns on a falling clock edge
    task automatic send_frame(input logic [7:0] data, input logic stop_bit);
        RX = 1'b0;
        start_cyc = cyc;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = data[i];
            repeat (B) @(negedge clk);
        end
        RX = stop_bit;
        repeat (B) @(negedge clk);
        RX = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- reset and idle ----
        rst_n = 1'b0;
        RX    = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("reset_rdy",      32'(rdy),      32'd0);
        check("reset_cmd",      32'(cmd),      32'h00);
        check("reset_go",       32'(cmd_go),   32'd0);
        check("reset_stop",     32'(cmd_stop), 32'd0);
        check("reset_frm_err",  32'(frm_err),  32'd0);
        check("reset_strobes",  32'(go_pulses + stop_pulses), 32'd0);
        exp_cmd = 8'h00;

        // ---- go command ----
        g0 = go_pulses; s0 = stop_pulses;
        send_frame(GO_CMD_DEF, 1'b1);
        repeat (4) @(negedge clk);
        exp_cmd = GO_CMD_DEF;
        lat = rdy_rise_cyc - start_cyc;
        check("go_rdy",        32'(rdy), 32'd1);
        check("go_cmd",        32'(cmd), 32'(exp_cmd));
        check("go_pulse_len",  32'(go_pulses - g0), 32'd1);
        check("go_no_stop",    32'(stop_pulses - s0), 32'd0);
        check("go_latency_ok", 32'((lat >= 153) && (lat <= 157)), 32'd1);

        // ---- stop command, then consumer acknowledge ----
        g0 = go_pulses; s0 = stop_pulses;
        send_frame(STOP_CMD_DEF, 1'b1);
        repeat (4) @(negedge clk);
        exp_cmd = STOP_CMD_DEF;
        check("stop_cmd",       32'(cmd), 32'(exp_cmd));
        check("stop_pulse_len", 32'(stop_pulses - s0), 32'd1);
        check("stop_no_go",     32'(go_pulses - g0), 32'd0);
        check("stop_rdy",       32'(rdy), 32'd1);
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
        check("clr_rdy_clears", 32'(rdy), 32'd0);
        check("clr_cmd_held",   32'(cmd), 32'(exp_cmd));

        // ---- back-to-back frames, no acknowledge ----
        g0 = go_pulses; s0 = stop_pulses;
        send_frame(8'hA5, 1'b1);
        check("b2b_first_cmd", 32'(cmd), 32'hA5);
        send_frame(8'h3C, 1'b1);
        repeat (4) @(negedge clk);
        exp_cmd = 8'h3C;
        check("b2b_second_cmd", 32'(cmd), 32'(exp_cmd));
        check("b2b_rdy",        32'(rdy), 32'd1);
        check("b2b_no_strobes", 32'(go_pulses - g0 + stop_pulses - s0), 32'd0);

        // ---- random bytes against the byte-level model ----
        for (int n = 0; n < 8; n++) begin
            b = 8'($urandom_range(0, 255));
            if (n == 2) b = GO_CMD_DEF;
            if (n == 5) b = STOP_CMD_DEF;
            gap = int'($urandom_range(0, 20));
            if ($urandom_range(0, 1) == 1) begin
                clr_rdy = 1'b1;
                @(negedge clk);
                clr_rdy = 1'b0;
            end
            repeat (gap) @(negedge clk);
            g0 = go_pulses; s0 = stop_pulses;
            send_frame(b, 1'b1);
            repeat (4) @(negedge clk);
            exp_cmd = b;
            check("rand_cmd",  32'(cmd), 32'(exp_cmd));
            check("rand_rdy",  32'(rdy), 32'd1);
            check("rand_go",   32'(go_pulses - g0),   32'(b == GO_CMD_DEF));
            check("rand_stop", 32'(stop_pulses - s0), 32'(b == STOP_CMD_DEF));
        end

        // ---- short low glitch on the line ----
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
        g0 = go_pulses; s0 = stop_pulses; r0 = rdy_rises;
        RX = 1'b0;
        repeat (4) @(negedge clk);
        RX = 1'b1;
        repeat (60) @(negedge clk);
        check("glitch_rdy",      32'(rdy), 32'd0);
        check("glitch_cmd_held", 32'(cmd), 32'(exp_cmd));
        check("glitch_no_rise",  32'(rdy_rises - r0), 32'd0);
        check("glitch_strobes",  32'(go_pulses - g0 + stop_pulses - s0), 32'd0);

        // ---- asynchronous reset in the middle of a go frame ----
        g0 = go_pulses;
        RX = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            RX = GO_CMD_DEF[i];
            repeat (B) @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check("async_rst_cmd", 32'(cmd), 32'h00);
        check("async_rst_rdy", 32'(rdy), 32'd0);
        RX = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        exp_cmd = 8'h00;
        repeat (200) @(negedge clk);
        check("post_rst_rdy", 32'(rdy), 32'd0);
        check("post_rst_go",  32'(go_pulses - g0), 32'd0);
        check("post_rst_cmd", 32'(cmd), 32'(exp_cmd));

        // ---- low stop bit, then a clean stop command ----
        send_frame(8'h3C, 1'b1);
        repeat (4) @(negedge clk);
        exp_cmd = 8'h3C;
        check("pre_frm_cmd", 32'(cmd), 32'(exp_cmd));
        g0 = go_pulses; r0 = rdy_rises; f0 = frm_hi;
        send_frame(GO_CMD_DEF, 1'b0);
        repeat (40) @(negedge clk);
`ifdef UART_CMD_RX_FRAME_CHK_EN
        check("frm_err_raised",  32'(frm_hi > f0), 32'd1);
        check("frm_cmd_held",    32'(cmd), 32'(exp_cmd));
        check("frm_no_go",       32'(go_pulses - g0), 32'd0);
        check("frm_no_rdy_rise", 32'(rdy_rises - r0), 32'd0);
`else
        exp_cmd = GO_CMD_DEF;
        check("nochk_frm_err",  32'(frm_hi - f0), 32'd0);
        check("nochk_cmd",      32'(cmd), 32'(exp_cmd));
        check("nochk_go",       32'(go_pulses - g0), 32'd1);
        check("nochk_rdy_rise", 32'(rdy_rises - r0), 32'd1);
`endif
        s0 = stop_pulses;
        send_frame(STOP_CMD_DEF, 1'b1);
        repeat (4) @(negedge clk);
        exp_cmd = STOP_CMD_DEF;
        check("recover_frm_err", 32'(frm_err), 32'd0);
        check("recover_cmd",     32'(cmd), 32'(exp_cmd));
        check("recover_stop",    32'(stop_pulses - s0), 32'd1);
        check("recover_rdy",     32'(rdy), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_uart_cmd_rx
`default_nettype wire
